// File: rtl/radix_4_div_pkg.sv
// ---------------------------------------------------------------------------
// radix_4_div_pkg
// Shared definitions for the radix-4 SRT divider iteration controller:
//   - one-hot FSM state enum plus the bit index of each state
//   - bit indices of the sign-coder one-hot quotient digit (-2..+2)
//   - one-hot digit patterns and the 2-bit digit values appended by the
//     on-the-fly quotient conversion
//   - debug struct exposing the controller state
// ---------------------------------------------------------------------------
package radix_4_div_pkg;

   localparam int ST_IDLE_IDX = 0;
   localparam int ST_PRE_IDX  = 1;
   localparam int ST_ITER_IDX = 2;
   localparam int ST_POST_IDX = 3;
   localparam int ST_DONE_IDX = 4;

   typedef enum logic [4:0] {
      S_IDLE = 5'b00001,
      S_PRE  = 5'b00010,
      S_ITER = 5'b00100,
      S_POST = 5'b01000,
      S_DONE = 5'b10000
   } state_e;

   // Bit positions inside the sign-coder digit: bit 4..0 = +2,+1,0,-1,-2.
   localparam int QUOT_NEG_2 = 0;
   localparam int QUOT_NEG_1 = 1;
   localparam int QUOT_ZERO  = 2;
   localparam int QUOT_POS_1 = 3;
   localparam int QUOT_POS_2 = 4;

   localparam logic [4:0] OH_NEG_2 = 5'(1 << QUOT_NEG_2);
   localparam logic [4:0] OH_NEG_1 = 5'(1 << QUOT_NEG_1);
   localparam logic [4:0] OH_ZERO  = 5'(1 << QUOT_ZERO);
   localparam logic [4:0] OH_POS_1 = 5'(1 << QUOT_POS_1);
   localparam logic [4:0] OH_POS_2 = 5'(1 << QUOT_POS_2);

   // Low two bits shifted into Q/QM by one conversion step.
   localparam logic [1:0] DIG_V0 = 2'd0;
   localparam logic [1:0] DIG_V1 = 2'd1;
   localparam logic [1:0] DIG_V2 = 2'd2;
   localparam logic [1:0] DIG_V3 = 2'd3;

   typedef struct packed {
      logic   dz_req;   // divisor_zero flag latched at the start handshake
      state_e state;    // current controller state
   } dbg_t;

endpackage

// File: rtl/radix_4_div_ctrl_if.sv
// ---------------------------------------------------------------------------
// radix_4_div_ctrl_if
// Bundles the request handshake, the datapath strobes/feedback and the
// result handshake of the radix-4 divider controller.
//   master : front-end / datapath side (drives *_i signals)
//   slave  : the controller (drives *_o signals)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The request side (start_valid_i/start_ready_o) and the result side
// (finish_valid_o/finish_ready_i) follow the same rule; once valid is raised
// it stays high, with its payload stable, until the transfer edge.
// ---------------------------------------------------------------------------
interface radix_4_div_ctrl_if #(
   parameter int WIDTH  = 32,
   parameter int ITER_W = $clog2(WIDTH/2+1)
);
   logic              start_valid_i;
   logic              start_ready_o;
   logic [ITER_W-1:0] iter_num_i;
   logic              quot_neg_i;
   logic              divisor_zero_i;
   logic [4:0]        quot_dig_i;
   logic              rem_neg_i;
   logic              pre_en_o;
   logic              iter_en_o;
   logic              post_en_o;
   logic              finish_valid_o;
   logic              finish_ready_i;
   logic [WIDTH-1:0]  quot_o;
   logic              div_zero_o;

   modport master (
      output start_valid_i, iter_num_i, quot_neg_i, divisor_zero_i,
             quot_dig_i, rem_neg_i, finish_ready_i,
      input  start_ready_o, pre_en_o, iter_en_o, post_en_o,
             finish_valid_o, quot_o, div_zero_o
   );

   modport slave (
      input  start_valid_i, iter_num_i, quot_neg_i, divisor_zero_i,
             quot_dig_i, rem_neg_i, finish_ready_i,
      output start_ready_o, pre_en_o, iter_en_o, post_en_o,
             finish_valid_o, quot_o, div_zero_o
   );
endinterface

// File: rtl/radix_4_otf_conv.sv
// ---------------------------------------------------------------------------
// radix_4_otf_conv
// On-the-fly conversion of signed radix-4 digits into a binary quotient.
// Keeps Q (value so far) and QM (Q - 1) so that negative digits never need
// a carry-propagating subtraction.
// Ports:
//   clk, rst   clock, synchronous active-high reset (Q=0, QM=all ones)
//   i_init     reinitialise Q/QM for a new division
//   i_en       apply i_dig this cycle
//   i_dig      one-hot digit, bit 4..0 = +2,+1,0,-1,-2
//   o_q, o_qm  Q and QM registers
// ---------------------------------------------------------------------------
module radix_4_otf_conv
   import radix_4_div_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_init,
   input  logic             i_en,
   input  logic [4:0]       i_dig,
   output logic [WIDTH-1:0] o_q,
   output logic [WIDTH-1:0] o_qm
);

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_qm;
   logic [WIDTH-1:0] w_q_nxt;
   logic [WIDTH-1:0] w_qm_nxt;

   // Shifts are left by 2, truncated to WIDTH. Anything that is not a clean
   // one-hot digit (including the explicit zero digit) takes the d=0 path.
   always_comb begin
      w_q_nxt  = {r_q[WIDTH-3:0],  DIG_V0};
      w_qm_nxt = {r_qm[WIDTH-3:0], DIG_V3};
      case (i_dig)
         OH_POS_2: begin
            w_q_nxt  = {r_q[WIDTH-3:0], DIG_V2};
            w_qm_nxt = {r_q[WIDTH-3:0], DIG_V1};
         end
         OH_POS_1: begin
            w_q_nxt  = {r_q[WIDTH-3:0], DIG_V1};
            w_qm_nxt = {r_q[WIDTH-3:0], DIG_V0};
         end
         OH_NEG_1: begin
            w_q_nxt  = {r_qm[WIDTH-3:0], DIG_V3};
            w_qm_nxt = {r_qm[WIDTH-3:0], DIG_V2};
         end
         OH_NEG_2: begin
            w_q_nxt  = {r_qm[WIDTH-3:0], DIG_V2};
            w_qm_nxt = {r_qm[WIDTH-3:0], DIG_V1};
         end
         default: begin
            w_q_nxt  = {r_q[WIDTH-3:0],  DIG_V0};
            w_qm_nxt = {r_qm[WIDTH-3:0], DIG_V3};
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || i_init) begin
         r_q  <= '0;
         r_qm <= '1;
      end else if (i_en) begin
         r_q  <= w_q_nxt;
         r_qm <= w_qm_nxt;
      end
   end

   assign o_q  = r_q;
   assign o_qm = r_qm;

endmodule

// File: rtl/radix_4_div_ctrl.sv
// ---------------------------------------------------------------------------
// radix_4_div_ctrl
// Iteration controller for the radix-4 SRT integer divider. Accepts a divide
// request, strobes the datapath through PRE, N ITER cycles and POST, builds
// the quotient on the fly and returns it over the result handshake.
// Ports:
//   clk       clock, all state changes on the rising edge
//   rst       synchronous, active-high reset
//   bus       radix_4_div_ctrl_if.slave (handshakes, strobes, digit, result)
//   o_dbg     current FSM state and latched divide-by-zero request
// Build option:
//   RADIX_4_DIV_CTRL_DIV_ZERO_EN  when defined, a request flagged with
//   divisor_zero_i skips the iterations and returns an all-ones quotient with
//   div_zero_o=1. When undefined, divisor_zero_i has no effect on the result.
// ---------------------------------------------------------------------------
module radix_4_div_ctrl
   import radix_4_div_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int ITER_W = $clog2(WIDTH/2+1)
) (
   input  logic                clk,
   input  logic                rst,
   radix_4_div_ctrl_if.slave   bus,
   output dbg_t                o_dbg
);

   localparam logic [ITER_W-1:0] MAX_ITER = ITER_W'(WIDTH/2);
   localparam logic [ITER_W-1:0] ONE_ITER = ITER_W'(1);

   state_e            r_state;
   logic [ITER_W-1:0] r_cnt;
   logic [ITER_W-1:0] r_iter_m1;
   logic              r_quot_neg;
   logic              r_dz_req;
   logic [WIDTH-1:0]  r_quot;
   logic              r_div_zero;

   logic [4:0]        w_state_bits;
   logic [ITER_W-1:0] w_n_clamp;
   logic              w_start;
   logic [WIDTH-1:0]  w_q;
   logic [WIDTH-1:0]  w_qm;
   logic [WIDTH-1:0]  w_corr;
   logic [WIDTH-1:0]  w_result;

   assign w_state_bits = r_state;
   assign w_start      = w_state_bits[ST_IDLE_IDX] & bus.start_valid_i;

   // Requested iteration count forced into 1..WIDTH/2.
   always_comb begin
      w_n_clamp = bus.iter_num_i;
      if (bus.iter_num_i == '0)
         w_n_clamp = ONE_ITER;
      else if (bus.iter_num_i > MAX_ITER)
         w_n_clamp = MAX_ITER;
   end

   // Negative final remainder means the quotient overshot by one: use QM.
   assign w_corr   = bus.rem_neg_i ? w_qm : w_q;
   assign w_result = r_quot_neg ? (-w_corr) : w_corr;

   radix_4_otf_conv #(.WIDTH(WIDTH)) u_otf (
      .clk    (clk),
      .rst    (rst),
      .i_init (w_start),
      .i_en   (w_state_bits[ST_ITER_IDX]),
      .i_dig  (bus.quot_dig_i),
      .o_q    (w_q),
      .o_qm   (w_qm)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_iter_m1  <= '0;
         r_quot_neg <= 1'b0;
         r_dz_req   <= 1'b0;
         r_quot     <= '0;
         r_div_zero <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start_valid_i) begin
                  r_iter_m1  <= w_n_clamp - ONE_ITER;
                  r_quot_neg <= bus.quot_neg_i;
                  r_dz_req   <= bus.divisor_zero_i;
                  r_div_zero <= 1'b0;
                  r_state    <= S_PRE;
               end
            end
            S_PRE: begin
`ifdef RADIX_4_DIV_CTRL_DIV_ZERO_EN
               if (r_dz_req) begin
                  r_quot     <= '1;
                  r_div_zero <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_cnt   <= r_iter_m1;
                  r_state <= S_ITER;
               end
`else
               r_cnt   <= r_iter_m1;
               r_state <= S_ITER;
`endif
            end
            S_ITER: begin
               // Counter holds the number of ITER cycles still to come.
               if (r_cnt == '0)
                  r_state <= S_POST;
               else
                  r_cnt <= r_cnt - ONE_ITER;
            end
            S_POST: begin
               r_quot  <= w_result;
               r_state <= S_DONE;
            end
            S_DONE: begin
               if (bus.finish_ready_i)
                  r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Strobes come straight from the one-hot state register bits.
   assign bus.start_ready_o  = w_state_bits[ST_IDLE_IDX];
   assign bus.pre_en_o       = w_state_bits[ST_PRE_IDX];
   assign bus.iter_en_o      = w_state_bits[ST_ITER_IDX];
   assign bus.post_en_o      = w_state_bits[ST_POST_IDX];
   assign bus.finish_valid_o = w_state_bits[ST_DONE_IDX];
   assign bus.quot_o         = r_quot;
   assign bus.div_zero_o     = r_div_zero;

   assign o_dbg.dz_req = r_dz_req;
   assign o_dbg.state  = r_state;

endmodule
